// File: rtl/snake_dir_queue.sv
// Snake direction queue: per-player FIFO of pending turns that are
// filtered against the last queued direction and consumed on each move tick.

`ifndef KEY_W
`define KEY_W 8'h1D
`endif
`ifndef KEY_A
`define KEY_A 8'h1C
`endif
`ifndef KEY_S
`define KEY_S 8'h1B
`endif
`ifndef KEY_D
`define KEY_D 8'h23
`endif
`ifndef KEY_I
`define KEY_I 8'h43
`endif
`ifndef KEY_J
`define KEY_J 8'h3B
`endif
`ifndef KEY_K
`define KEY_K 8'h42
`endif
`ifndef KEY_L
`define KEY_L 8'h4B
`endif

module snake_dir_queue #(
    parameter int NUM_PLAYERS   = 1,
    parameter int QDEPTH        = 4,
    parameter bit ALLOW_REVERSE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               key,
    input  logic                     key_pressed,
    input  logic                     step,
    output logic [2*NUM_PLAYERS-1:0] snake_dir,
    output logic [NUM_PLAYERS-1:0]   pending,
    output logic [NUM_PLAYERS-1:0]   overflow
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
        localparam logic [7:0] K_UP = (p == 0) ? `KEY_W : `KEY_I;
        localparam logic [7:0] K_LF = (p == 0) ? `KEY_A : `KEY_J;
        localparam logic [7:0] K_DN = (p == 0) ? `KEY_S : `KEY_K;
        localparam logic [7:0] K_RT = (p == 0) ? `KEY_D : `KEY_L;
        localparam logic [1:0] DIR0 = (p == 0) ? 2'b10 : 2'b01;

        logic [1:0]    fifo_q [QDEPTH];
        logic [PW-1:0] head_q, head_d;
        logic [PW-1:0] tail_q, tail_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [1:0]    dir_q, dir_d;
        logic          ovf_q, ovf_d;
        logic          hit;
        logic [1:0]    cand;
        logic [1:0]    last;
        logic          accept;
        logic          push;
        logic          pop;

        // Map a key press to this player's candidate direction
        always_comb begin
            hit  = key_pressed;
            cand = 2'b00;
            if (key == K_UP)      cand = 2'b00;
            else if (key == K_LF) cand = 2'b01;
            else if (key == K_RT) cand = 2'b10;
            else if (key == K_DN) cand = 2'b11;
            else                  hit  = 1'b0;
        end

        // New turns are judged against the newest queued turn, else the live heading
        assign last   = (cnt_q != '0) ? fifo_q[tail_q - PW'(1)] : dir_q;
        assign pop    = step && (cnt_q != '0);
        assign accept = hit && (cand != last) &&
                        (ALLOW_REVERSE || (cand != ~last));
        assign push   = accept && ((cnt_q < CW'(QDEPTH)) || pop);

        // Next-state for pointers, count, heading and sticky overflow
        always_comb begin
            head_d = head_q;
            tail_d = tail_q;
            cnt_d  = cnt_q;
            dir_d  = dir_q;
            ovf_d  = ovf_q;
            if (start) begin
                head_d = '0;
                tail_d = '0;
                cnt_d  = '0;
                ovf_d  = 1'b0;
                dir_d  = DIR0;
            end else begin
                if (pop) begin
                    dir_d  = fifo_q[head_q];
                    head_d = head_q + PW'(1);
                end
                if (push)
                    tail_d = tail_q + PW'(1);
                if (accept && !push)
                    ovf_d = 1'b1;
                if (push && !pop)
                    cnt_d = cnt_q + CW'(1);
                else if (pop && !push)
                    cnt_d = cnt_q - CW'(1);
            end
        end

        // Control state with asynchronous active-low reset
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                head_q <= '0;
                tail_q <= '0;
                cnt_q  <= '0;
                dir_q  <= 2'b00;
                ovf_q  <= 1'b0;
            end else begin
                head_q <= head_d;
                tail_q <= tail_d;
                cnt_q  <= cnt_d;
                dir_q  <= dir_d;
                ovf_q  <= ovf_d;
            end
        end

        // Entry storage; contents are meaningless while the count is zero
        always_ff @(posedge clk) begin
            if (push && !start)
                fifo_q[tail_q] <= cand;
        end

        assign snake_dir[2*p +: 2] = dir_q;
        assign pending[p]          = (cnt_q != '0);
        assign overflow[p]         = ovf_q;
    end

endmodule

// File: tb/tb_snake_dir_queue.sv
// Directed bench for snake_dir_queue: two-player depth-4 no-reverse
// instance plus a one-player depth-2 reverse-allowed instance.

module tb_snake_dir_queue;

    localparam logic [7:0] KW = 8'h1D;
    localparam logic [7:0] KA = 8'h1C;
    localparam logic [7:0] KS = 8'h1B;
    localparam logic [7:0] KD = 8'h23;
    localparam logic [7:0] KI = 8'h43;
    localparam logic [7:0] KJ = 8'h3B;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] key = 8'h00;
    logic       kp = 1'b0;
    logic       step = 1'b0;
    logic [3:0] dir;
    logic [1:0] pend;
    logic [1:0] ovf;

    logic       start_b = 1'b0;
    logic [7:0] key_b = 8'h00;
    logic       kp_b = 1'b0;
    logic       step_b = 1'b0;
    logic [1:0] dir_b;
    logic       pend_b;
    logic       ovf_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    snake_dir_queue #(
        .NUM_PLAYERS(2), .QDEPTH(4), .ALLOW_REVERSE(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .key(key),
        .key_pressed(kp), .step(step),
        .snake_dir(dir), .pending(pend), .overflow(ovf)
    );

    snake_dir_queue #(
        .NUM_PLAYERS(1), .QDEPTH(2), .ALLOW_REVERSE(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .key(key_b),
        .key_pressed(kp_b), .step(step_b),
        .snake_dir(dir_b), .pending(pend_b), .overflow(ovf_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press(input logic [7:0] k);
        key = k;
        kp  = 1'b1;
        tick();
        kp  = 1'b0;
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic press_b(input logic [7:0] k);
        key_b = k;
        kp_b  = 1'b1;
        tick();
        kp_b  = 1'b0;
    endtask

    initial begin
        // Reset held
        #12;
        chk("rst_dir",  {4'h0, dir},  8'h00);
        chk("rst_pend", {6'h0, pend}, 8'h00);
        chk("rst_ovf",  {6'h0, ovf},  8'h00);
        chk("rst_dir_b", {6'h0, dir_b}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("idle_dir", {4'h0, dir}, 8'h00);

        // Start sets P1=left, P0=right
        do_start();
        chk("start_dir",  {4'h0, dir},  8'h06);
        chk("start_pend", {6'h0, pend}, 8'h00);
        chk("start_ovf",  {6'h0, ovf},  8'h00);

        // W queued, S rejected as reverse of queued up
        press(KW);
        chk("w_pend", {6'h0, pend}, 8'h01);
        chk("w_nobypass", {4'h0, dir}, 8'h06);
        press(KS);
        chk("s_pend", {6'h0, pend}, 8'h01);
        do_step();
        chk("ws_dir",  {4'h0, dir},  8'h04);
        chk("ws_pend", {6'h0, pend}, 8'h00);

        // Fill queue, fifth press overflows
        do_start();
        press(KW);
        press(KA);
        press(KS);
        press(KD);
        chk("full_ovf0", {6'h0, ovf}, 8'h00);
        press(KW);
        chk("full_ovf1", {6'h0, ovf},  8'h01);
        chk("full_pend", {6'h0, pend}, 8'h01);
        do_step();
        chk("pop1", {6'h0, dir[1:0]}, 8'h00);
        do_step();
        chk("pop2", {6'h0, dir[1:0]}, 8'h01);
        do_step();
        chk("pop3", {6'h0, dir[1:0]}, 8'h03);
        do_step();
        chk("pop4", {6'h0, dir[1:0]}, 8'h02);
        chk("pop4_pend", {6'h0, pend}, 8'h00);
        chk("ovf_sticky", {6'h0, ovf}, 8'h01);
        do_step();
        chk("empty_hold", {4'h0, dir}, 8'h06);

        // Full queue with press and step together
        do_start();
        chk("restart_ovf", {6'h0, ovf}, 8'h00);
        press(KW);
        press(KA);
        press(KS);
        press(KD);
        key  = KW;
        kp   = 1'b1;
        step = 1'b1;
        tick();
        kp   = 1'b0;
        step = 1'b0;
        chk("pp_dir", {6'h0, dir[1:0]}, 8'h00);
        chk("pp_ovf", {6'h0, ovf},      8'h00);
        do_step();
        chk("pp_pop2", {6'h0, dir[1:0]}, 8'h01);
        do_step();
        chk("pp_pop3", {6'h0, dir[1:0]}, 8'h03);
        do_step();
        chk("pp_pop4", {6'h0, dir[1:0]}, 8'h02);
        chk("pp_pend4", {6'h0, pend}, 8'h01);
        do_step();
        chk("pp_pop5", {6'h0, dir[1:0]}, 8'h00);
        chk("pp_pend5", {6'h0, pend}, 8'h00);

        // Player 1 keys and simultaneous press/step on empty queue
        do_start();
        press(KJ);
        chk("p1_same", {6'h0, pend}, 8'h00);
        press(KI);
        chk("p1_pend", {6'h0, pend}, 8'h02);
        key  = KW;
        kp   = 1'b1;
        step = 1'b1;
        tick();
        kp   = 1'b0;
        step = 1'b0;
        chk("sim_dir",  {4'h0, dir},  8'h02);
        chk("sim_pend", {6'h0, pend}, 8'h01);
        do_step();
        chk("sim_dir2",  {4'h0, dir},  8'h00);
        chk("sim_pend2", {6'h0, pend}, 8'h00);

        // Asynchronous reset discards queued turns
        do_start();
        press(KW);
        press(KA);
        press(KS);
        #2;
        rst = 1'b0;
        #2;
        chk("arst_dir",  {4'h0, dir},  8'h00);
        chk("arst_pend", {6'h0, pend}, 8'h00);
        tick();
        rst = 1'b1;
        do_step();
        do_step();
        chk("post_rst_dir",  {4'h0, dir},  8'h00);
        chk("post_rst_pend", {6'h0, pend}, 8'h00);

        // Reverse-allowed, depth-2, single player
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_start", {6'h0, dir_b}, 8'h02);
        press_b(KI);
        chk("b_p1_ignored", {7'h0, pend_b}, 8'h00);
        press_b(KD);
        chk("b_same", {7'h0, pend_b}, 8'h00);
        press_b(KA);
        chk("b_rev_pend", {7'h0, pend_b}, 8'h01);
        step_b = 1'b1;
        tick();
        step_b = 1'b0;
        chk("b_rev_dir", {6'h0, dir_b}, 8'h01);
        press_b(KW);
        press_b(KD);
        chk("b_ovf0", {7'h0, ovf_b}, 8'h00);
        press_b(KS);
        chk("b_ovf1", {7'h0, ovf_b}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_dir_queue.md
SNAKE_DIR_QUEUE -- requirements
Module: snake_dir_queue

Interface
REQ-001 The block SHALL have parameter NUM_PLAYERS, default 1, legal 1..2: number of independent snake channels.
REQ-002 The block SHALL have parameter QDEPTH, default 4, legal 2/4/8: pending-turn queue depth per player.
REQ-003 The block SHALL have parameter ALLOW_REVERSE, default 0: 1 = 180-degree turns accepted, 0 = rejected.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  synchronous game start/restart.
REQ-007 key  input  8  key code from keyboard decoder.
REQ-008 key_pressed  input  1  key valid strobe, one cycle per press.
REQ-009 step  input  1  game move tick, one cycle per snake move.
REQ-010 snake_dir  output  2*NUM_PLAYERS  current direction, player p at bits [2p+1:2p].
REQ-011 pending  output  NUM_PLAYERS  bit p = player p queue non-empty.
REQ-012 overflow  output  NUM_PLAYERS  bit p = sticky, turn dropped because queue full.

Function
REQ-013 Direction encoding SHALL be up=00, left=01, right=10, down=11; opposite(d) = ~d.
REQ-014 Player 0 SHALL map `KEY_W/`KEY_A/`KEY_S/`KEY_D to up/left/down/right; player 1 SHALL map `KEY_I/`KEY_J/`KEY_K/`KEY_L identically, all codes from keys.v.
REQ-015 Keys not mapped to an existing player SHALL be ignored with no state change.
REQ-016 Each player SHALL own a FIFO of QDEPTH 2-bit entries plus a count of width clog2(QDEPTH)+1.
REQ-017 Reference direction "last" SHALL be the tail entry if the queue is non-empty, else current snake_dir.
REQ-018 A mapped press with candidate d SHALL be dropped silently if d == last.
REQ-019 A mapped press SHALL be dropped silently if ALLOW_REVERSE==0 and d == ~last.
REQ-020 Otherwise the press SHALL be enqueued if count<QDEPTH, or if count==QDEPTH and step pops in the same cycle.
REQ-021 Otherwise (full, no pop) the press SHALL be dropped and overflow[p] set to 1.
REQ-022 On step with count>0, snake_dir[p] SHALL load the head entry on that edge and the entry SHALL be popped.
REQ-023 On step with count==0, snake_dir[p] SHALL hold.
REQ-024 Latency: a press enqueued into an empty queue SHALL appear on snake_dir no earlier than the edge of the next step after the press cycle; no same-cycle bypass.
REQ-025 Simultaneous press and step on an empty queue SHALL compare d against pre-edge snake_dir, enqueue it, and leave snake_dir unchanged.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; head/tail pointers SHALL wrap modulo QDEPTH.
REQ-027 start SHALL have priority over step and key_pressed in the same cycle.
REQ-028 start SHALL flush all queues, clear overflow, and set player 0 = right (10) and player 1 = left (01).
REQ-029 overflow[p] SHALL clear only on start or reset.
REQ-030 pending[p] SHALL equal (count!=0), registered state, no combinational path from inputs.

Reset
REQ-031 While rst==0, all snake_dir bits SHALL be 00, all counts and pointers 0, pending=0, overflow=0, asynchronously.
REQ-032 Reset assertion mid-operation SHALL discard queued turns immediately; after rst release, state SHALL change only by start/key/step.

Verification
REQ-033 rst low, then high, start pulse -> snake_dir=01_10 (NUM_PLAYERS=2), pending=00, overflow=00.
REQ-034 After start (P0=10): press W, press S, step -> W enqueued, S dropped as reverse of queued up (ALLOW_REVERSE=0), after step snake_dir[1:0]=00, pending[0]=0.
REQ-035 QDEPTH=4, P0=10: press W,A,S,D,W, no step -> first four accepted (alternating, no reverse), fifth dropped, overflow[0]=1; four steps yield 00,01,11,10; overflow stays 1.
REQ-036 Queue full, press and step same cycle -> head popped to snake_dir, new entry accepted, count remains 4, overflow unchanged.
REQ-037 P0=10, empty queue, press D -> dropped (same as current); press A with ALLOW_REVERSE=1 -> enqueued, step gives 01.
REQ-038 Three turns queued, rst pulsed low one cycle mid-sequence -> snake_dir=00, pending=0 immediately; subsequent steps leave snake_dir=00.
